// File: rtl/acc_readout.sv
// Streaming readout engine for the accumulator: sweeps an address range, reads one word per
// cycle through a fixed-latency RAM port, buffers returns in a credit-managed FIFO and presents
// them as a valid/ready stream. Optionally zeroes each word in the same cycle it is read.
module acc_readout #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned RD_LATENCY = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH:0]   length_i,
  input  logic                  clear_en_i,
  output logic                  busy_o,
  output logic                  done_o,
  // Accumulator read port
  output logic                  rd_en_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  input  logic [DATA_WIDTH-1:0] rd_rdata_i,
  // Accumulator write port
  output logic                  wr_en_o,
  output logic                  wr_we_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [DATA_WIDTH-1:0] wr_wdata_o,
  output logic                  acc_mode_o,
  // Output stream
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_last_o
);

  localparam int unsigned CntW = ADDR_WIDTH + 1;
  localparam int unsigned InfW = $clog2(RD_LATENCY + 1);
  localparam int unsigned FcW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [CntW-1:0]       len_q, len_d;
  logic                  clr_q, clr_d;
  logic [CntW-1:0]       issue_cnt_q, issue_cnt_d;
  logic [CntW-1:0]       out_cnt_q, out_cnt_d;
  logic [InfW-1:0]       inflight_q, inflight_d;
  logic [RD_LATENCY-1:0] tag_q, tag_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [FcW-1:0]        fifo_cnt_q, fifo_cnt_d;

  logic        start_ok, issue, push, pop, last_word;
  logic [31:0] credits_used;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(FIFO_DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Handshake and issue qualifiers; credits count both buffered and in-flight words.
  always_comb begin
    start_ok     = (state_q == StIdle) && start_i;
    credits_used = 32'(inflight_q) + 32'(fifo_cnt_q);
    issue        = (state_q == StRun) && (credits_used < FIFO_DEPTH) && (issue_cnt_q < len_q);
    push         = tag_q[RD_LATENCY-1];
    pop          = (fifo_cnt_q != '0) && m_ready_i;
    last_word    = (out_cnt_q == len_q - CntW'(1));
  end

  // Job sequencing.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_i) state_d = (length_i == '0) ? StDone : StRun;
      StRun:   if (issue && (issue_cnt_q == len_q - CntW'(1))) state_d = StDrain;
      StDrain: if (pop && last_word) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Job parameters, progress counters and read-return tagging.
  always_comb begin
    base_d      = base_q;
    len_d       = len_q;
    clr_d       = clr_q;
    issue_cnt_d = issue_cnt_q;
    out_cnt_d   = out_cnt_q;
    if (start_ok) begin
      base_d      = base_addr_i;
      len_d       = length_i;
      clr_d       = clear_en_i;
      issue_cnt_d = '0;
      out_cnt_d   = '0;
    end else begin
      if (issue) issue_cnt_d = issue_cnt_q + CntW'(1);
      if (pop)   out_cnt_d   = out_cnt_q + CntW'(1);
    end
    inflight_d = inflight_q + InfW'(issue) - InfW'(push);
    tag_d[0]   = issue;
    for (int i = 1; i < int'(RD_LATENCY); i++) tag_d[i] = tag_q[i-1];
  end

  // FIFO pointer and occupancy update.
  always_comb begin
    wptr_d     = push ? ptr_inc(wptr_q) : wptr_q;
    rptr_d     = pop  ? ptr_inc(rptr_q) : rptr_q;
    fifo_cnt_d = fifo_cnt_q + FcW'(push) - FcW'(pop);
  end

  // State registers; reset discards any in-flight returns.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      base_q      <= '0;
      len_q       <= '0;
      clr_q       <= 1'b0;
      issue_cnt_q <= '0;
      out_cnt_q   <= '0;
      inflight_q  <= '0;
      tag_q       <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      fifo_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      clr_q       <= clr_d;
      issue_cnt_q <= issue_cnt_d;
      out_cnt_q   <= out_cnt_d;
      inflight_q  <= inflight_d;
      tag_q       <= tag_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
    end
  end

  // FIFO storage; cleared on reset so the idle head reads as zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wptr_q] <= rd_rdata_i;
    end
  end

  // Port drive: addresses wrap modulo the address space; clear shares the read address.
  always_comb begin
    busy_o     = (state_q != StIdle);
    done_o     = (state_q == StDone);
    rd_en_o    = issue;
    rd_addr_o  = issue ? base_q + issue_cnt_q[ADDR_WIDTH-1:0] : '0;
    wr_en_o    = issue && clr_q;
    wr_we_o    = issue && clr_q;
    wr_addr_o  = (issue && clr_q) ? rd_addr_o : '0;
    wr_wdata_o = '0;
    acc_mode_o = 1'b0;
    m_valid_o  = (fifo_cnt_q != '0);
    m_data_o   = mem_q[rptr_q];
    m_last_o   = m_valid_o && last_word;
  end

endmodule

// File: doc/acc_readout.md
# acc_readout

Streaming readout engine for the accumulator: the reader at the other end of the accumulator's read port. On `start` it sweeps a contiguous address range, issues one-word reads at up to one per cycle, absorbs the fixed RAM read latency in a small credit-managed FIFO, and presents the words as a valid/ready stream with a `last` marker. In the same cycle as each read it can optionally zero the word through the accumulator's write port in overwrite mode (mode=0), so the bank is clean for the next accumulation pass.

## Interface
- `ADDR_WIDTH`, 9, accumulator address width.
- `DATA_WIDTH`, 64, word width (four 16-bit lanes, passed through unmodified).
- `RD_LATENCY`, 2, cycles from read-request cycle (en=1) to `rdata` valid; must be ≥1.
- `FIFO_DEPTH`, 4, output buffer entries; must be ≥ RD_LATENCY+1 for full throughput.
- `clk` in 1: clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle pulse, accepted only in IDLE.
- `base_addr` in ADDR_WIDTH: first address, sampled on accepted start.
- `length` in ADDR_WIDTH+1: word count 0..2^ADDR_WIDTH, sampled on accepted start.
- `clear_en` in 1: zero each word after reading it, sampled on accepted start.
- `busy` out 1: high from the accepted start through the DONE cycle.
- `done` out 1: one-cycle pulse after the last word has been handshaked (or immediately for length=0).
- `rd_port` ram_if.read_master: drives `en`, `addr`; samples `rdata`.
- `wr_port` ram_if.write_master: drives `en`, `we`, `addr`, `wdata`.
- `acc_mode` out 1: drives accumulator `mode`; constant 0 (overwrite).
- `m_valid` out 1, `m_ready` in 1, `m_data` out DATA_WIDTH, `m_last` out 1: output stream.

## Operation
- FSM: IDLE → (start & length≠0) RUN; IDLE → (start & length=0) DONE; RUN → (final read issued) DRAIN; DRAIN → (FIFO empty & no reads outstanding) DONE; DONE → IDLE (1 cycle).
- Counters: `issue_cnt` and `out_cnt` are ADDR_WIDTH+1 bits, and a credit counter `inflight` is 0..RD_LATENCY.
- Issue condition in RUN: `inflight + fifo_count < FIFO_DEPTH`. On issue:
  - `rd_port.en`=1, `addr`=base_addr+issue_cnt mod 2^ADDR_WIDTH (wraps past max address).
  - `issue_cnt` increments.
- Clear: when clear_en is set, each issue cycle also drives `wr_port.en`=`we`=1, same addr, `wdata`=0. No write occurs otherwise.
- Return path: a RD_LATENCY-deep valid shift register tags the returning `rdata`, which is pushed into the FIFO in its valid cycle. A push can never meet a full FIFO, because credits guarantee space.
- Stream: `m_valid` = FIFO not empty, `m_data` = FIFO head. `m_last` = head is word length-1 (out_cnt = length-1). A pop happens on m_valid & m_ready.
- `m_data` must stay stable while m_valid & !m_ready.
- start outside IDLE is ignored. Parameters sampled on start are held until DONE.
- Precondition: no accumulate-mode writes to the accumulator while busy. The block does not check this.

## Timing
- Reset values: busy=0, done=0, m_valid=0, m_last=0, m_data=0, rd_port.en=0, wr_port.en/we=0, addr=0, wdata=0, acc_mode=0; FSM=IDLE; all counters 0; FIFO empty.
- Start accepted at cycle T: busy=1 at T+1, first read issue at T+1.
- First word: m_valid at T+1+RD_LATENCY+1 (one cycle for the FIFO register).
- With m_ready held high, one word per cycle; N words finish at cycle T+RD_LATENCY+1+N.
- done pulses the cycle after the last pop; busy drops the cycle after done.
- length=0: busy=1 and done=1 at T+1, busy=0 at T+2; no port activity.
- Backpressure: with m_ready=0, issue stops after FIFO_DEPTH words are held or in flight, and resumes the cycle after a pop frees a credit.
- Reset mid-operation clears all state immediately. In-flight returns are discarded, and the range may be partly cleared.

## Test plan
- Preload addr 0..7 with 0x0001_0002_0003_0004·(i+1); start base=0, length=8, clear_en=0, m_ready=1:
  - 8 words in order, contiguous cycles, m_last on the 8th.
  - done 1 cycle after; RAM unchanged.
- base=510, length=4, ADDR_WIDTH=9: reads addr 510, 511, 0, 1; m_last on the addr-1 word.
- clear_en=1, base=16, length=4:
  - stream returns the preloaded values.
  - A second readout of addr 16..19 returns all zeros; addr 20 is untouched.
- m_ready toggled 1,0,0,1 repeating, length=16:
  - all 16 words delivered exactly once, in order.
  - m_data stable while stalled; never more than FIFO_DEPTH words outstanding.
- length=0: done at T+1, no rd/wr en. A start pulse while busy is ignored: the count and addresses of the first job are unchanged.
- Assert rstn low mid-RUN, release, start base=0, length=2:
  - outputs at reset values during reset.
  - the new job delivers exactly 2 correct words with no stale data.
